status_reg_unit: RTL and testbench
==================================

// Module: status_reg_unit
// PURPOSE
//  Producer side of the NZCV condition flags. Collects flag updates from ALU instructions with the S bit set and
//  holds them in a commit pipeline until they retire into the architectural status register. Drives the 4-bit
//  {N,Z,C,V} status seen by the condition checker and raises a flag hazard toward ID.
//  Also keeps a saved-status shadow for exception entry and return.
// PARAMETERS
//  COMMIT_DEPTH  2  number of stages from EXE to flag commit (1..4); entry COMMIT_DEPTH-1 commits
// PORTS
//  clk             in   1  single clock, rising edge
//  rst             in   1  synchronous, active-high reset
//  exe_valid       in   1  valid instruction in EXE
//  exe_s           in   1  EXE instruction writes flags (S bit)
//  alu_status      in   4  {N,Z,C,V} produced by the ALU this cycle
//  stall           in   1  pipeline frozen: hold pending pipe, no commit
//  flush           in   1  kill in-flight (younger) flag updates
//  id_valid        in   1  valid instruction in ID
//  id_cond         in   4  condition field of the ID instruction
//  save_req        in   1  copy architectural status to saved shadow
//  restore_req     in   1  load architectural status from saved shadow
//  status_out      out  4  {N,Z,C,V} delivered to the condition checker
//  arch_status     out  4  committed architectural NZCV
//  saved_status    out  4  saved-status shadow
//  flag_hazard     out  1  ID must stall: its condition needs unavailable flags
//  restore_ready   out  1  no pending flag update in flight (EXE input included)
//  restore_err     out  1  sticky: restore_req seen while restore_ready=0
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): arch_status=0, saved_status=0, all pending valids=0, restore_err=0.
//    While pending is empty after reset: flag_hazard=0, restore_ready=1, status_out=0.
//  - Pending pipe: entries p[0..D-1], each {v, nzcv}. When stall=0, every clk:
//    p[0] <= {exe_valid&exe_s, alu_status}; p[i] <= p[i-1]; and if p[D-1].v then arch_status <= p[D-1].nzcv.
//    When stall=1, all entries hold and nothing commits.
//  - flush=1 (overrides stall for valids): EXE input and p[0..D-2] valids cleared. p[D-1] is older than the
//    flushing branch: it still commits this cycle if stall=0; if stall=1 it is held.
//  - needs_flags(c) = (c != COND_AL) && (c != COND_NV).
//  - pend_any = (exe_valid&exe_s) | OR(p[i].v). restore_ready = ~pend_any.
//  - flag_hazard = id_valid & needs_flags(id_cond) & pend_any. Combinational, no added latency.
//  - status_out = arch_status (combinational).
//  - save_req: saved_status <= arch_status at the edge, using the value before any same-cycle commit.
//  - restore_req with restore_ready=1: arch_status <= saved_status.
//    restore_req with restore_ready=0: request ignored; restore_err <= 1 (sticky until rst).
//  - save_req and restore_req in the same cycle: the two registers swap.
//  - rst mid-flight discards all pending entries; no commit occurs on the reset edge.
// CONFIGURATION
//  FLAG_FWD_EN defined:
//    status_out = nzcv of the youngest valid source, in priority EXE input > p[0] > ... > p[D-1] > arch_status.
//    flag_hazard is tied to 0.
//  FLAG_FWD_EN undefined: behaviour exactly as in BEHAVIOUR (stall on hazard, no forwarding).
// STRUCTURE
//  Shared package arm_status_pkg:
//    typedef logic [3:0] nzcv_t ({N,Z,C,V} order)
//    cond_t
//    COND_AL = 4'd14, COND_NV = 4'd15
//    function needs_flags(cond_t)
//  Sub-module status_pend_stage: one pending entry (v, nzcv) with stall/flush/kill control. It is
//  instantiated COMMIT_DEPTH times through a generate loop.
// TESTING
//  1. Reset, D=2; exe_valid=exe_s=1, alu_status=4'b0100, one cycle -> arch_status=4'b0100 two edges later.
//     flag_hazard=1 for id_cond=0 during those cycles, and 0 for id_cond=14.
//  2. Push 4'b1000, then flush next cycle with no stall -> arch_status stays 0.
//     Push, wait one edge so the entry is in p[D-1], then flush -> arch_status=4'b1000 on that edge.
//  3. stall=1 for 3 cycles with an entry in p[1] -> arch_status unchanged until stall drops,
//     then committed on the next edge.
//  4. arch=4'b0010; save_req -> saved=4'b0010. Change arch to 4'b1001, then restore_req with an empty pipe ->
//     arch=4'b0010. restore_req with a pending entry -> arch unchanged, restore_err=1 and sticky.
//  5. FLAG_FWD_EN: EXE pushes 4'b0100 while p[0] holds 4'b1000 -> status_out=4'b0100, flag_hazard=0.
//     Without the macro -> status_out=arch, flag_hazard=1.
//  6. rst asserted with 2 pending entries -> all valids cleared, arch_status=0, restore_ready=1 the next cycle.

Source files
------------

// File: rtl/arm_status_pkg.sv
// Shared NZCV types, condition-code constants and the flag-need helper used
// by the status register unit and its pending-stage sub-module.
package arm_status_pkg;

    typedef logic [3:0] nzcv_t;   // {N,Z,C,V}
    typedef logic [3:0] cond_t;

    localparam cond_t COND_AL = 4'd14;
    localparam cond_t COND_NV = 4'd15;

    // AL and NV never look at the flags; every other condition does.
    function automatic logic needs_flags(input cond_t c);
        return (c != COND_AL) && (c != COND_NV);
    endfunction

endpackage : arm_status_pkg

// File: rtl/status_pend_stage.sv
// One entry of the flag commit pipe: a valid bit plus the NZCV it carries.
// stall freezes the entry; flush kills the entry arriving from a younger
// source, and also kills the held entry unless this is the commit stage
// (the commit-stage entry is older than the flushing branch).
module status_pend_stage
    import arm_status_pkg::*;
#(
    parameter bit IS_LAST = 1'b0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  stall,
    input  logic  flush,
    input  logic  in_v,
    input  nzcv_t in_nzcv,
    output logic  v,
    output nzcv_t nzcv
);

    logic  v_r;
    nzcv_t nzcv_r;
    logic  kill_self_s;

    assign kill_self_s = flush & ~IS_LAST;

    // Advance, hold or kill the entry each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r    <= 1'b0;
            nzcv_r <= 4'b0000;
        end else if (stall) begin
            v_r    <= v_r & ~kill_self_s;
            nzcv_r <= nzcv_r;
        end else begin
            v_r    <= in_v & ~flush;
            nzcv_r <= in_nzcv;
        end
    end

    assign v    = v_r;
    assign nzcv = nzcv_r;

endmodule : status_pend_stage

// File: rtl/status_reg_unit.sv
// NZCV producer: collects S-bit ALU flag updates in a COMMIT_DEPTH-deep pipe,
// retires them into the architectural status register, keeps a saved-status
// shadow for exception entry/return and raises a flag hazard toward ID.
// Optional feature macro FLAG_FWD_EN: forward the youngest in-flight flags to
// status_out and never raise flag_hazard.
module status_reg_unit
    import arm_status_pkg::*;
#(
    parameter int COMMIT_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       exe_valid,
    input  logic       exe_s,
    input  logic [3:0] alu_status,
    input  logic       stall,
    input  logic       flush,
    input  logic       id_valid,
    input  logic [3:0] id_cond,
    input  logic       save_req,
    input  logic       restore_req,
    output logic [3:0] status_out,
    output logic [3:0] arch_status,
    output logic [3:0] saved_status,
    output logic       flag_hazard,
    output logic       restore_ready,
    output logic       restore_err
);

    localparam int D = COMMIT_DEPTH;

    logic [D-1:0] pv_s;
    nzcv_t        pnz_s [D];
    logic         exe_upd_s;
    logic         pend_any_s;
    nzcv_t        arch_r;
    nzcv_t        saved_r;
    logic         err_r;

    assign exe_upd_s = exe_valid & exe_s;

    generate
        for (genvar gi = 0; gi < D; gi++) begin : g_stage
            logic  in_v_s;
            nzcv_t in_nz_s;
            if (gi == 0) begin : g_head
                assign in_v_s  = exe_upd_s;
                assign in_nz_s = alu_status;
            end else begin : g_body
                assign in_v_s  = pv_s[gi-1];
                assign in_nz_s = pnz_s[gi-1];
            end
            status_pend_stage #(
                .IS_LAST (gi == D - 1)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .stall   (stall),
                .flush   (flush),
                .in_v    (in_v_s),
                .in_nzcv (in_nz_s),
                .v       (pv_s[gi]),
                .nzcv    (pnz_s[gi])
            );
        end
    endgenerate

    assign pend_any_s = exe_upd_s | (|pv_s);

    // Architectural status: restore (only legal with an empty pipe) or commit of the oldest entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            arch_r <= 4'b0000;
        end else if (restore_req && !pend_any_s) begin
            arch_r <= saved_r;
        end else if (!stall && pv_s[D-1]) begin
            arch_r <= pnz_s[D-1];
        end else begin
            arch_r <= arch_r;
        end
    end

    // Saved shadow captures the pre-commit architectural value; swaps with a same-cycle restore.
    always_ff @(posedge clk) begin
        if (rst) begin
            saved_r <= 4'b0000;
        end else if (save_req) begin
            saved_r <= arch_r;
        end else begin
            saved_r <= saved_r;
        end
    end

    // Sticky error for a restore attempted while flag updates are still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (restore_req && pend_any_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Flags seen by the condition checker and the ID-stage hazard.
    always_comb begin
        status_out  = arch_r;
        flag_hazard = 1'b0;
`ifdef FLAG_FWD_EN
        for (int i = D - 1; i >= 0; i--) begin
            if (pv_s[i]) begin
                status_out = pnz_s[i];
            end else begin
                status_out = status_out;
            end
        end
        if (exe_upd_s) begin
            status_out = alu_status;
        end else begin
            status_out = status_out;
        end
`else
        flag_hazard = id_valid & needs_flags(id_cond) & pend_any_s;
`endif
    end

    assign arch_status   = arch_r;
    assign saved_status  = saved_r;
    assign restore_ready = ~pend_any_s;
    assign restore_err   = err_r;

endmodule : status_reg_unit

// File: tb/tb_status_reg_unit.sv
// Scoreboard bench for status_reg_unit: each stimulus cycle pushes the
// expected outputs computed from a queue-of-in-flight-updates model; a
// negedge monitor pops and compares. Directed scenarios then random traffic.
module tb_status_reg_unit;

    localparam int D = 2;

    logic       clk;
    logic       rst;
    logic       exe_valid;
    logic       exe_s;
    logic [3:0] alu_status;
    logic       stall;
    logic       flush;
    logic       id_valid;
    logic [3:0] id_cond;
    logic       save_req;
    logic       restore_req;
    logic [3:0] status_out;
    logic [3:0] arch_status;
    logic [3:0] saved_status;
    logic       flag_hazard;
    logic       restore_ready;
    logic       restore_err;

    status_reg_unit #(.COMMIT_DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .exe_valid     (exe_valid),
        .exe_s         (exe_s),
        .alu_status    (alu_status),
        .stall         (stall),
        .flush         (flush),
        .id_valid      (id_valid),
        .id_cond       (id_cond),
        .save_req      (save_req),
        .restore_req   (restore_req),
        .status_out    (status_out),
        .arch_status   (arch_status),
        .saved_status  (saved_status),
        .flag_hazard   (flag_hazard),
        .restore_ready (restore_ready),
        .restore_err   (restore_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each in-flight update knows how many stages it has travelled.
    typedef struct {
        logic [3:0] nz;
        int         pos;
    } item_t;
    item_t      pend_q[$];
    logic [3:0] m_arch;
    logic [3:0] m_saved;
    logic       m_err;

    typedef struct {
        logic [3:0] so;
        logic [3:0] arch;
        logic [3:0] saved;
        logic       haz;
        logic       rdy;
        logic       err;
    } exp_t;
    exp_t sb_q[$];

    int checks   = 0;
    int failures = 0;

    function automatic logic needs(input logic [3:0] c);
        return (c != 4'd14) && (c != 4'd15);
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic ev, input logic es, input logic [3:0] alu,
                        input logic st, input logic fl, input logic idv, input logic [3:0] idc,
                        input logic sv, input logic rs);
        exp_t       e;
        logic       pa;
        int         best;
        item_t      nq[$];
        item_t      it;
        logic [3:0] n_arch;
        logic [3:0] n_saved;
        rst = r; exe_valid = ev; exe_s = es; alu_status = alu; stall = st; flush = fl;
        id_valid = idv; id_cond = idc; save_req = sv; restore_req = rs;
        pa      = (ev && es) || (pend_q.size() != 0);
        e.arch  = m_arch;
        e.saved = m_saved;
        e.err   = m_err;
        e.rdy   = !pa;
`ifdef FLAG_FWD_EN
        e.haz = 1'b0;
        e.so  = m_arch;
        best  = D;
        foreach (pend_q[k]) begin
            if (pend_q[k].pos < best) begin
                best = pend_q[k].pos;
                e.so = pend_q[k].nz;
            end
        end
        if (ev && es) e.so = alu;
`else
        best  = 0;
        e.haz = idv && needs(idc) && pa;
        e.so  = m_arch;
`endif
        sb_q.push_back(e);
        @(posedge clk);
        if (r) begin
            pend_q.delete();
            m_arch  = 4'b0000;
            m_saved = 4'b0000;
            m_err   = 1'b0;
        end else begin
            n_arch  = m_arch;
            n_saved = sv ? m_arch : m_saved;
            if (rs) begin
                if (!pa) n_arch = m_saved;
                else     m_err  = 1'b1;
            end
            foreach (pend_q[k]) begin
                it = pend_q[k];
                if (fl && it.pos < D - 1) continue;
                if (st) nq.push_back(it);
                else if (it.pos == D - 1) n_arch = it.nz;
                else begin
                    it.pos = it.pos + 1;
                    nq.push_back(it);
                end
            end
            if (!st && ev && es && !fl) nq.push_back('{alu, 0});
            pend_q  = nq;
            m_arch  = n_arch;
            m_saved = n_saved;
        end
        #1;
    endtask

    task automatic idle(input logic [3:0] idc = 4'd0);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, idc, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [3:0] nz, input logic [3:0] idc = 4'd0);
        step(1'b0, 1'b1, 1'b1, nz, 1'b0, 1'b0, 1'b1, idc, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    // Monitor: compare every cycle's outputs against the queued expectation.
    always @(negedge clk) begin
        exp_t m;
        if (sb_q.size() > 0) begin
            m = sb_q.pop_front();
            chk("status_out",    status_out,           m.so);
            chk("arch_status",   arch_status,          m.arch);
            chk("saved_status",  saved_status,         m.saved);
            chk("flag_hazard",   {3'b000, flag_hazard},   {3'b000, m.haz});
            chk("restore_ready", {3'b000, restore_ready}, {3'b000, m.rdy});
            chk("restore_err",   {3'b000, restore_err},   {3'b000, m.err});
        end
    end

    initial begin
        m_arch = 4'b0000; m_saved = 4'b0000; m_err = 1'b0;
        rst = 1'b1; exe_valid = 1'b0; exe_s = 1'b0; alu_status = 4'b0000; stall = 1'b0;
        flush = 1'b0; id_valid = 1'b0; id_cond = 4'd0; save_req = 1'b0; restore_req = 1'b0;
        @(posedge clk); #1;

        // 1: basic commit latency and hazard condition filter
        do_reset();
        chk("t1_reset_arch", arch_status, 4'b0000);
        chk("t1_reset_rdy",  {3'b000, restore_ready}, 4'b0001);
        push(4'b0100, 4'd0);
        idle(4'd0);
        idle(4'd14);
        chk("t1_commit", arch_status, 4'b0100);

        // 2: flush of a young entry vs flush with the entry at the commit stage
        do_reset();
        push(4'b1000);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        idle(); idle();
        chk("t2_flush_young", arch_status, 4'b0000);
        push(4'b1000);
        idle();
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("t2_flush_old", arch_status, 4'b1000);

        // 3: stall holds the commit-stage entry
        push(4'b0001);
        idle();
        repeat (3) begin
            step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
            chk("t3_stall_hold", arch_status, 4'b1000);
        end
        idle();
        chk("t3_after_stall", arch_status, 4'b0001);

        // 4: save / restore / illegal restore
        push(4'b0010); idle(); idle();
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        chk("t4_saved", saved_status, 4'b0010);
        push(4'b1001); idle(); idle();
        chk("t4_arch_new", arch_status, 4'b1001);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        chk("t4_restored", arch_status, 4'b0010);
        push(4'b0111);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        chk("t4_bad_restore_arch", arch_status, 4'b0010);
        chk("t4_err", {3'b000, restore_err}, 4'b0001);
        idle(); idle();
        chk("t4_err_sticky", {3'b000, restore_err}, 4'b0001);
        chk("t4_late_commit", arch_status, 4'b0111);

        // 5: forwarding versus hazard with EXE and p[0] both valid
        push(4'b1000);
        exe_valid = 1'b1; exe_s = 1'b1; alu_status = 4'b0100; id_valid = 1'b1; id_cond = 4'd0;
        stall = 1'b0; flush = 1'b0; save_req = 1'b0; restore_req = 1'b0; rst = 1'b0;
        #2;
`ifdef FLAG_FWD_EN
        chk("t5_fwd_status", status_out, 4'b0100);
        chk("t5_fwd_hazard", {3'b000, flag_hazard}, 4'b0000);
`else
        chk("t5_status", status_out, 4'b0111);
        chk("t5_hazard", {3'b000, flag_hazard}, 4'b0001);
`endif
        push(4'b0100);

        // 6: reset with two entries in flight
        push(4'b0011);
        do_reset();
        chk("t6_arch", arch_status, 4'b0000);
        chk("t6_rdy", {3'b000, restore_ready}, 4'b0001);
        chk("t6_err", {3'b000, restore_err}, 4'b0000);
        idle(); idle();
        chk("t6_no_commit", arch_status, 4'b0000);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [3:0] c;
            c = ($urandom_range(0, 3) == 0) ? 4'(14 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)), c, ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
        end

        @(posedge clk); #1;
        chk("sb_drain", 4'(sb_q.size()), 4'b0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_status_reg_unit
